// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- shared definitions for the iterative multiply/divide unit.
//   XLEN      : operand width (only 32 is supported)
//   OP_*      : operation encodings carried on the op port
//   state_t   : control FSM states
//   mag()     : magnitude of a value, treating it as signed only when asked
package muldiv_pkg;

   localparam int XLEN = 32;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic is_signed);
      return (is_signed && v[XLEN-1]) ? -v : v;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step -- one iteration of the shared multiply/divide datapath.
// Purely combinational.
//   is_div  : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_in  : {high, low} accumulator before the step
//   operand : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   acc_out : accumulator after the step
// Multiply: low half starts as the multiplier; its LSB selects whether the
//   multiplicand is added into the high half, then the 65-bit {carry,acc}
//   shifts right one place.
// Divide: low half starts as the dividend; the accumulator shifts left one
//   place, a 33-bit trial subtract of the divisor decides the quotient bit,
//   which enters at the bottom of the low half.
module muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic              is_div,
   input  logic [2*XLEN-1:0] acc_in,
   input  logic [XLEN-1:0]   operand,
   output logic [2*XLEN-1:0] acc_out
);

   logic [XLEN:0]   sum;
   logic [XLEN:0]   rem_sh;
   logic [XLEN+1:0] diff;
   logic            unused_diff_bit;

   always_comb begin
      sum    = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, operand} : '0);
      rem_sh = acc_in[2*XLEN-1:XLEN-1];
      diff   = {1'b0, rem_sh} - {2'b00, operand};
      if (is_div) begin
         // A successful subtract always leaves a value below the divisor,
         // so the low XLEN bits hold the whole new remainder.
         if (diff[XLEN+1])
            acc_out = {rem_sh[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
         else
            acc_out = {diff[XLEN-1:0], acc_in[XLEN-2:0], 1'b1};
      end else begin
         acc_out = {sum, acc_in[XLEN-1:1]};
      end
   end

   assign unused_diff_bit = diff[XLEN];

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative MIPS-style multiply/divide unit with HI/LO.
// Fixed 34-cycle latency: 32 CALC cycles, one FIX cycle that applies the
// sign correction and writes HI/LO, then a one-cycle DONE pulse.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start, op, A, B : launch an operation (sampled only while not busy)
//   mthi, mtlo      : write wdata to HI / LO (ignored while busy)
//   hilo_rd         : an mfhi/mflo is in decode
//   HI, LO          : architectural result registers
//   busy, done      : operation in flight / one-cycle completion pulse
//   stall           : pipeline freeze while busy and HI/LO or the unit is wanted
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   input  logic            mthi,
   input  logic            mtlo,
   input  logic [XLEN-1:0] wdata,
   input  logic            hilo_rd,
   output logic [XLEN-1:0] HI,
   output logic [XLEN-1:0] LO,
   output logic            busy,
   output logic            done,
   output logic            stall
);

   state_t            state, state_nxt;
   logic [4:0]        cnt;
   logic [2*XLEN-1:0] acc, acc_step;
   logic [XLEN-1:0]   hi_r, lo_r;
   logic [XLEN-1:0]   a_raw, b_mag;
   logic              is_div, b_zero, neg_q, neg_r;
   logic              op_signed;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   q_fix, r_fix;

   muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div  (is_div),
      .acc_in  (acc),
      .operand (b_mag),
      .acc_out (acc_step)
   );

   assign busy      = (state == CALC) || (state == FIX);
   assign done      = (state == DONE);
   assign stall     = busy & (hilo_rd | start | mthi | mtlo);
   assign HI        = hi_r;
   assign LO        = lo_r;
   assign op_signed = ~op[0];

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: state_nxt = start ? CALC : IDLE;
         CALC:       if (cnt == 5'd0) state_nxt = FIX;
         FIX:        state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
   end

   // Sign correction applied on the FIX edge. For mult neg_q marks a
   // negative product; for div it marks a negative quotient.
   always_comb begin
      prod_fix = neg_q ? -acc : acc;
      q_fix    = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      r_fix    = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         acc    <= '0;
         hi_r   <= '0;
         lo_r   <= '0;
         a_raw  <= '0;
         b_mag  <= '0;
         is_div <= 1'b0;
         b_zero <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (!busy) begin
            if (mthi) hi_r <= wdata;
            if (mtlo) lo_r <= wdata;
            if (start) begin
               cnt    <= 5'd31;
               acc    <= {{XLEN{1'b0}}, mag(A, op_signed)};
               b_mag  <= mag(B, op_signed);
               a_raw  <= A;
               is_div <= op[1];
               b_zero <= (B == '0);
               neg_q  <= op_signed & (A[XLEN-1] ^ B[XLEN-1]);
               neg_r  <= op_signed & A[XLEN-1];
            end
         end
         if (state == CALC) begin
            acc <= acc_step;
            if (cnt != 5'd0) cnt <= cnt - 5'd1;
         end
         if (state == FIX) begin
            if (!is_div) begin
               {hi_r, lo_r} <= prod_fix;
            end else if (b_zero) begin
               // Divide by zero: raw dividend in HI, all-ones quotient, no sign fix.
               hi_r <= a_raw;
               lo_r <= '1;
            end else begin
               hi_r <= r_fix;
               lo_r <= q_fix;
            end
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- directed plus randomized bench for muldiv_unit.
// Expected HI/LO come from plain integer arithmetic on the operands.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        reset, start, mthi, mtlo, hilo_rd;
   logic [1:0]  op;
   logic [31:0] A, B, wdata;
   logic [31:0] HI, LO;
   logic        busy, done, stall;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.XLEN(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
      .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .hilo_rd(hilo_rd),
      .HI(HI), .LO(LO), .busy(busy), .done(done), .stall(stall)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      int     ia, ib, q, r;
      longint la, lb;
      logic [63:0] res;
      ia = a; ib = b;
      la = ia; lb = ib;
      case (o)
         OP_MULT:  res = la * lb;
         OP_MULTU: res = {32'h0, a} * {32'h0, b};
         OP_DIV: begin
            if (b == 32'h0)                                res = {a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
            else begin
               q = ia / ib;
               r = ia % ib;
               res = {r, q};
            end
         end
         default: begin
            if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
            else            res = {a % b, a / b};
         end
      endcase
      return res;
   endfunction

   // Called at a falling edge; returns at the falling edge of cycle 1.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      op = o; A = a; B = b; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_result(input string tag, input logic [1:0] o, input logic [31:0] a,
                              input logic [31:0] b, input int n0, input bit hold);
      int n;
      logic [63:0] exp;
      n   = n0;
      exp = model(o, a, b);
      while (!done && n < 60) begin
         if (hold) chk({tag, "_stall_busy"}, stall, 1);
         @(negedge clk);
         n++;
      end
      chk({tag, "_latency"}, n, 34);
      chk({tag, "_busy_done"}, {done, busy}, 2'b10);
      chk({tag, "_hilo"}, {HI, LO}, exp);
      if (hold) chk({tag, "_stall_done"}, stall, 0);
   endtask

   task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      issue(o, a, b);
      wait_result(tag, o, a, b, 1, 1'b0);
   endtask

   initial begin
      logic [31:0] hi_before, lo_before, ra, rb;
      logic [1:0]  ro;
      bit          seen;

      reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; hilo_rd = 1'b0;
      op = OP_MULT; A = '0; B = '0; wdata = '0;
      repeat (3) @(negedge clk);
      chk("reset_state", {HI, LO, busy, done, stall}, '0);
      reset = 1'b0;

      // mthi / mtlo while idle
      mthi = 1'b1; wdata = 32'hA5A5_0001;
      @(negedge clk);
      mthi = 1'b0; mtlo = 1'b1; wdata = 32'h5A5A_0002;
      @(negedge clk);
      mtlo = 1'b0;
      chk("mthi_mtlo", {HI, LO}, {32'hA5A5_0001, 32'h5A5A_0002});

      // directed results
      run("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("multu_max_exact", {HI, LO}, {32'hFFFF_FFFE, 32'h0000_0001});
      run("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7);
      chk("mult_neg_exact", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
      run("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2);
      chk("div_neg_exact", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      run("divu_zero", OP_DIVU, 32'd100, 32'd0);
      chk("divu_zero_exact", {HI, LO}, {32'h0000_0064, 32'hFFFF_FFFF});
      run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("div_ovf_exact", {HI, LO}, {32'h0, 32'h8000_0000});
      run("div_neg_zero", OP_DIV, 32'hFFFF_FF00, 32'd0);

      // mthi together with start: HI written now, result overwrites later
      @(negedge clk);
      mthi = 1'b1; wdata = 32'hCAFE_0003;
      issue(OP_MULTU, 32'd6, 32'd9);
      chk("mthi_with_start", HI, 32'hCAFE_0003);
      mthi = 1'b0;
      wait_result("start_mthi", OP_MULTU, 32'd6, 32'd9, 1, 1'b0);

      // start / mthi / mtlo while busy are ignored
      issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
      hi_before = HI; lo_before = LO;
      start = 1'b1; mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_1234;
      op = OP_DIVU; A = 32'd1000; B = 32'd3;
      repeat (3) begin
         chk("busy_ignore_stall", stall, 1);
         @(negedge clk);
      end
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      chk("busy_ignore_hilo", {HI, LO}, {hi_before, lo_before});
      wait_result("busy_ignore", OP_MULT, 32'hFFFF_FFFD, 32'd7, 4, 1'b0);

      // hilo_rd held across an op, then back-to-back start in DONE
      hilo_rd = 1'b1;
      issue(OP_DIVU, 32'd1000, 32'd7);
      wait_result("hilo_rd_a", OP_DIVU, 32'd1000, 32'd7, 1, 1'b1);
      issue(OP_DIV, 32'hFFFF_FC18, 32'd7);
      wait_result("hilo_rd_b2b", OP_DIV, 32'hFFFF_FC18, 32'd7, 1, 1'b1);
      hilo_rd = 1'b0;

      // randomized operations
      for (int i = 0; i < 24; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         case ($urandom_range(0, 7))
            0:       rb = 32'h0;
            1:       rb = 32'($urandom_range(1, 15));
            2:       rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 1) == 1) @(negedge clk);
         run("random", ro, ra, rb);
      end

      // reset beats start and mthi in the same cycle
      @(negedge clk);
      reset = 1'b1; start = 1'b1; mthi = 1'b1; wdata = 32'hDEAD_BEEF;
      op = OP_MULTU; A = 32'd3; B = 32'd3;
      @(negedge clk);
      reset = 1'b0; start = 1'b0; mthi = 1'b0;
      chk("reset_priority", {HI, LO, busy}, '0);
      @(negedge clk);
      chk("reset_priority_nostart", {busy, done}, 2'b00);

      // reset mid-operation discards it
      wdata = 32'h1111_2222; mthi = 1'b1; mtlo = 1'b1;
      @(negedge clk);
      mthi = 1'b0; mtlo = 1'b0;
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_reset_state", {HI, LO, busy, done}, '0);
      seen = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk("mid_reset_no_done", seen, 0);
      chk("mid_reset_hilo_kept", {HI, LO}, '0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
